seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
- Controller that sequences parallel words through a serial overlapping pattern detector, one bit per clock, MSB first.
- Counts pattern hits per word and returns the count over a valid/ready handshake.
- Sits between a word-wide producer and a consumer, so the bit-serial "110"/"1101" detector can be used on byte streams.
- Detector history persists across words: the input is treated as one continuous bit stream.

Parameters:
- WORD_W, 8, bits per input word.
- CNT_W, 4, width of the per-word hit counter. Counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  WORD_W  word to scan, MSB shifted first
- in_mode  in  1  0 = detect "110", 1 = detect "1101"; sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_count  out  CNT_W  hits found in the word
- det_pulse  out  1  one-cycle strobe on each hit
- busy  out  1  high in SHIFT or REPORT

Behaviour:
- One clock domain.
- Reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values: FSM IDLE, in_ready=1, out_valid=0, out_count=0, det_pulse=0, busy=0, detector state S0, stored mode=0.
- Controller FSM:
  - IDLE: in_ready=1. When in_valid=1 at a clock edge:
    - latch in_data into the shift register and in_mode into the mode register;
    - clear bit counter and hit counter;
    - go to SHIFT.
  - SHIFT: lasts exactly WORD_W cycles. Each cycle:
    - drive shreg MSB to the detector and shift left;
    - increment bit counter;
    - if hit, increment the hit counter (saturating).
    - After the WORD_W-th bit, go to REPORT.
  - REPORT: out_valid=1 and out_count stable. When out_ready=1, go to IDLE.
  - While out_ready=0, hold REPORT with all outputs stable and in_ready=0.
- Latency: accept edge is cycle 0. Bits are processed in cycles 1..WORD_W. out_valid is high from cycle WORD_W+1. If out_ready is held high, the earliest next accept is cycle WORD_W+2.
- Detector core: Mealy, overlapping, 4 states.
  - States: S0 (no prefix), S1 ("1"), S2 ("11"), S3 ("110").
  - S0: 1→S1, 0→S0
  - S1: 1→S2, 0→S0
  - S2: 1→S2, 0→S3
  - S3: 1→S1, 0→S0
  - hit (combinational, same cycle as bit): mode0 when state=S2 and din=0; mode1 when state=S3 and din=1.
  - Core state advances only when en=1, i.e. in SHIFT.
- det_pulse = hit & SHIFT. It is combinational and aligned to the bit's cycle.
- Hit counter saturates at 2^CNT_W-1 and never wraps.
- Mode change: if the in_mode sampled on accept differs from the stored mode, the core state is cleared to S0 on the accept edge. If the mode is unchanged, core state is retained.
- Simultaneous events:
  - in_valid during SHIFT or REPORT is ignored (in_ready=0); the producer must hold.
  - REPORT handoff and the next accept cannot occur in the same cycle.
- Reset mid-SHIFT or mid-REPORT: the next edge returns everything to reset values. No result is emitted for an aborted word.

Decomposition:
- Package seq_scan_pkg holds:
  - controller state encoding: IDLE=2'b00, SHIFT=2'b01, REPORT=2'b10;
  - detector state encoding: S0..S3 = 2'b00..2'b11;
  - mode constants MODE_110=1'b0, MODE_1101=1'b1.
- Sub-module seq_det_core holds the 4-state Mealy detector.
  - Ports: clk, rst, en, clr, mode, din, hit.
  - clr has priority over en.

Test Plan:
- Reset, then mode0, in_data=8'b1101_1000 → det_pulse in bit cycles 3 and 6, out_count=2 at cycle 9.
- Same word in mode1 → det_pulse only in bit cycle 4, out_count=1.
- Mode0 8'b0000_0011 (count 0), then mode0 8'b0000_0000 → second word count=1, with det_pulse in its first bit cycle (history carried).
- Repeat the previous pair but switch to mode1 on the second word → core cleared, second count=0.
- WORD_W=16, CNT_W=2, mode0 16'b1101101101101101 → 5 raw hits, out_count saturates at 3.
- Hold out_ready=0 for 5 cycles in REPORT, with in_valid=1 → out_count stable, in_ready=0, no accept. Then assert rst in mid-SHIFT of the next word → all outputs at reset values next cycle, and no out_valid is produced for that word.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared encodings for the word-to-bit-serial scan controller and its pattern detector.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_e;

    localparam logic MODE_110  = 1'b0;
    localparam logic MODE_1101 = 1'b1;

    // Mealy hit: "110" completes from S2 on a 0, "1101" completes from S3 on a 1.
    function automatic logic det_hit(input det_state_e st, input logic mode, input logic din);
        if (mode == MODE_110) begin
            return (st == S2) && !din;
        end
        return (st == S3) && din;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Overlapping 4-state Mealy detector for "110" / "1101"; clr beats en.
module seq_det_core
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic mode,
    input  logic din,
    output logic hit
);

    det_state_e state_q;
    det_state_e state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S2 : S0;
            S2:      state_d = din ? S2 : S3;
            S3:      state_d = din ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= S0;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    assign hit = det_hit(state_q, mode, din);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Feeds accepted words MSB-first into the detector and reports a saturating hit count per word.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              det_pulse,
    output logic              busy
);

    localparam int unsigned     BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    ctrl_state_e       state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic              mode_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic accept;
    logic shifting;
    logic core_clr;
    logic core_hit;

    assign accept   = in_ready_q && in_valid;
    assign shifting = (state_q == SHIFT);
    // A new mode invalidates the carried prefix history.
    assign core_clr = accept && (in_mode != mode_q);

    seq_det_core u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (shifting),
        .clr  (core_clr),
        .mode (mode_q),
        .din  (shreg_q[WORD_W-1]),
        .hit  (core_hit)
    );

    assign det_pulse = core_hit && shifting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hit_cnt_q   <= '0;
            mode_q      <= MODE_110;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q    <= in_data;
                        mode_q     <= in_mode;
                        bit_cnt_q  <= '0;
                        hit_cnt_q  <= '0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg_q   <= shreg_q << 1;
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    if (det_pulse && (hit_cnt_q != CNT_MAX)) begin
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q     <= REPORT;
                        out_valid_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = hit_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed and random words against a suffix-match bit-history model.
module tb_seq_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_ready;
    logic        in_mode;
    logic [15:0] din_w;
    logic        iv0, iv1;
    logic        rdy0, rdy1, ov0, ov1, dp0, dp1, bz0, bz1;
    logic [3:0]  cnt0;
    logic [1:0]  cnt1;

    int errors = 0;
    int checks = 0;

    // Model: recent stream bits since the last history clear, plus stored mode.
    logic [3:0] hist  [2];
    int         hlen  [2];
    logic       mmode [2];

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in_data(din_w[7:0]),
        .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready), .out_count(cnt0),
        .det_pulse(dp0), .busy(bz0)
    );

    seq_scan_ctrl #(.WORD_W(16), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_data(din_w),
        .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_count(cnt1),
        .det_pulse(dp1), .busy(bz1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            hist[d]  = '0;
            hlen[d]  = 0;
            mmode[d] = 1'b0;
        end
    endtask

    task automatic model_accept(input int d, input logic mode);
        if (mode != mmode[d]) hlen[d] = 0;
        mmode[d] = mode;
    endtask

    // A hit is the stream's latest bits ending in the selected pattern.
    task automatic model_step(input int d, input logic b, output logic h);
        hist[d] = {hist[d][2:0], b};
        if (hlen[d] < 4) hlen[d]++;
        if (mmode[d] == 1'b0) h = (hlen[d] >= 3) && (hist[d][2:0] == 3'b110);
        else                  h = (hlen[d] >= 4) && (hist[d] == 4'b1101);
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (((d != 0) ? rdy1 : rdy0) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", (d != 0) ? rdy1 : rdy0, 1);
    endtask

    task automatic run_word(input int d, input logic [15:0] data, input logic mode,
                            input int hold, input int exp_cnt);
        int   w   = (d != 0) ? 16 : 8;
        int   sat = (d != 0) ? 3 : 15;
        int   cnt = 0;
        logic h;
        logic [31:0] held;
        wait_ready(d);
        din_w     = data;
        in_mode   = mode;
        out_ready = (hold == 0);
        if (d != 0) iv1 = 1'b1; else iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        iv1 = 1'b0;
        model_accept(d, mode);
        chk("busy_in_shift", (d != 0) ? bz1 : bz0, 1);
        chk("in_ready_in_shift", (d != 0) ? rdy1 : rdy0, 0);
        for (int i = 0; i < w; i++) begin
            model_step(d, data[w-1-i], h);
            if (h && cnt < sat) cnt++;
            chk($sformatf("det_pulse_bit%0d", i + 1), (d != 0) ? dp1 : dp0, h);
            chk("no_out_valid_in_shift", (d != 0) ? ov1 : ov0, 0);
            @(negedge clk);
        end
        held = (d != 0) ? 32'(cnt1) : 32'(cnt0);
        chk("out_valid_report", (d != 0) ? ov1 : ov0, 1);
        chk("out_count", held, cnt);
        if (exp_cnt >= 0) chk("out_count_directed", held, exp_cnt);
        chk("in_ready_report", (d != 0) ? rdy1 : rdy0, 0);
        chk("det_pulse_report", (d != 0) ? dp1 : dp0, 0);
        for (int k = 0; k < hold; k++) begin
            if (d != 0) iv1 = 1'b1; else iv0 = 1'b1;
            din_w = 16'($urandom);
            @(negedge clk);
            chk("hold_out_valid", (d != 0) ? ov1 : ov0, 1);
            chk("hold_count_stable", (d != 0) ? 32'(cnt1) : 32'(cnt0), held);
            chk("hold_in_ready", (d != 0) ? rdy1 : rdy0, 0);
            chk("hold_busy", (d != 0) ? bz1 : bz0, 1);
        end
        iv0       = 1'b0;
        iv1       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", (d != 0) ? ov1 : ov0, 0);
        chk("idle_in_ready", (d != 0) ? rdy1 : rdy0, 1);
        chk("idle_busy", (d != 0) ? bz1 : bz0, 0);
    endtask

    task automatic abort_word(input logic [7:0] data, input logic mode, input int k);
        logic h;
        wait_ready(0);
        din_w   = {8'h00, data};
        in_mode = mode;
        iv0     = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        model_accept(0, mode);
        for (int i = 0; i < k; i++) begin
            model_step(0, data[7-i], h);
            chk("abort_det_pulse", dp0, h);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_in_ready", rdy0, 1);
        chk("abort_out_valid", ov0, 0);
        chk("abort_out_count", cnt0, 0);
        chk("abort_det_pulse_low", dp0, 0);
        chk("abort_busy", bz0, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_result_after_abort", ov0, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        iv0       = 1'b0;
        iv1       = 1'b0;
        out_ready = 1'b1;
        in_mode   = 1'b0;
        din_w     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_in_ready", rdy0, 1);
        chk("reset_out_valid", ov0, 0);
        chk("reset_out_count", cnt0, 0);
        chk("reset_det_pulse", dp0, 0);
        chk("reset_busy", bz0, 0);
        chk("reset_in_ready_w16", rdy1, 1);
        chk("reset_out_valid_w16", ov1, 0);

        run_word(0, 16'h00D8, 1'b0, 0, 2);
        run_word(0, 16'h00D8, 1'b1, 0, 1);
        run_word(0, 16'h0003, 1'b0, 0, 0);
        run_word(0, 16'h0000, 1'b0, 0, 1);
        run_word(0, 16'h0003, 1'b0, 0, 0);
        run_word(0, 16'h0000, 1'b1, 0, 0);
        run_word(1, 16'hDB6D, 1'b0, 0, 3);

        run_word(0, 16'h00B6, 1'b0, 5, -1);
        abort_word(8'hB7, 1'b0, 3);

        for (int n = 0; n < 40; n++) begin
            run_word(($urandom_range(0, 3) == 0) ? 1 : 0, 16'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
